// File: rtl/extend_pipe_if.sv
// Handshake bundle for extend_pipe: upstream push channel and downstream pop channel.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both high.
interface extend_pipe_if #(
    parameter int IN_W    = 4,
    parameter int OUT_W   = 9,
    parameter int SHAMT_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic [1:0]         mode;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_ovf;

    // Block-side view.
    modport slave (
        input  in_valid, in_data, mode, shamt, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

    // Environment-side view (decoder upstream, operand mux downstream).
    modport master (
        output in_valid, in_data, mode, shamt, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/extend_pipe.sv
// Immediate-extension stage (zero / sign / ones-fill / sign+shift) feeding a 2-entry FIFO.
// Optional EXTEND_PIPE_STATS_EN adds saturating push and overflow counters.
module extend_pipe #(
    parameter int IN_W    = 4,
    parameter int OUT_W   = 9,
    parameter int SHAMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    extend_pipe_if.slave     bus,
    output logic [1:0]       dbg_count_o
`ifdef EXTEND_PIPE_STATS_EN
    ,
    output logic [15:0]      acc_cnt,
    output logic [15:0]      ovf_cnt
`endif
);
    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_ONES  = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    // Wide enough that the largest shift never loses a significant bit.
    localparam int EXT_W = OUT_W + (1 << SHAMT_W) - 1;
    localparam int TOP_W = EXT_W - OUT_W + 1;

    logic [EXT_W-1:0] sext_w;
    logic [EXT_W-1:0] shifted_w;
    logic [TOP_W-1:0] top_w;
    logic [OUT_W-1:0] fill_w;
    logic [OUT_W-1:0] res_w;
    logic             ovf_w;

    logic [OUT_W-1:0] head_data_q, head_data_d;
    logic             head_ovf_q,  head_ovf_d;
    logic [OUT_W-1:0] tail_data_q, tail_data_d;
    logic             tail_ovf_q,  tail_ovf_d;
    logic [1:0]       count_q,     count_d;

    logic push_w;
    logic pop_w;

    always_comb begin
        sext_w    = {{(EXT_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
        shifted_w = sext_w << bus.shamt;
        top_w     = shifted_w[EXT_W-1:OUT_W-1];

        fill_w = OUT_W'(bus.in_data);
        for (int i = IN_W; i < OUT_W; i++) begin
            case (bus.mode)
                MODE_SIGN: fill_w[i] = bus.in_data[IN_W-1];
                MODE_ONES: fill_w[i] = 1'b1;
                default:   fill_w[i] = 1'b0;
            endcase
        end

        res_w = fill_w;
        ovf_w = 1'b0;
        if (bus.mode == MODE_SHIFT) begin
            res_w = shifted_w[OUT_W-1:0];
            // Overflow: the kept sign bit and everything above it are not all equal.
            ovf_w = !((&top_w) || !(|top_w));
        end
    end

    assign bus.in_ready  = rst && (count_q != CNT_FULL);
    assign bus.out_valid = (count_q != CNT_EMPTY);
    assign bus.out_data  = head_data_q;
    assign bus.out_ovf   = head_ovf_q;
    assign dbg_count_o   = count_q;

    assign push_w = bus.in_valid && bus.in_ready;
    assign pop_w  = bus.out_valid && bus.out_ready;

    always_comb begin
        head_data_d = head_data_q;
        head_ovf_d  = head_ovf_q;
        tail_data_d = tail_data_q;
        tail_ovf_d  = tail_ovf_q;
        count_d     = count_q;
        case (count_q)
            CNT_EMPTY: begin
                if (push_w) begin
                    head_data_d = res_w;
                    head_ovf_d  = ovf_w;
                    count_d     = CNT_ONE;
                end
            end
            CNT_ONE: begin
                if (push_w && pop_w) begin
                    head_data_d = res_w;
                    head_ovf_d  = ovf_w;
                end else if (push_w) begin
                    tail_data_d = res_w;
                    tail_ovf_d  = ovf_w;
                    count_d     = CNT_FULL;
                end else if (pop_w) begin
                    count_d = CNT_EMPTY;
                end
            end
            CNT_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop_w) begin
                    head_data_d = tail_data_q;
                    head_ovf_d  = tail_ovf_q;
                    count_d     = CNT_ONE;
                end
            end
            default: count_d = CNT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_data_q <= '0;
            head_ovf_q  <= 1'b0;
            tail_data_q <= '0;
            tail_ovf_q  <= 1'b0;
            count_q     <= CNT_EMPTY;
        end else begin
            head_data_q <= head_data_d;
            head_ovf_q  <= head_ovf_d;
            tail_data_q <= tail_data_d;
            tail_ovf_q  <= tail_ovf_d;
            count_q     <= count_d;
        end
    end

`ifdef EXTEND_PIPE_STATS_EN
    logic [15:0] acc_cnt_q, acc_cnt_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (push_w && (acc_cnt_q != 16'hFFFF)) acc_cnt_d = acc_cnt_q + 16'd1;
        if (push_w && ovf_w && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign acc_cnt = acc_cnt_q;
    assign ovf_cnt = ovf_cnt_q;
`endif
endmodule
